// File: rtl/job_sched.sv
// job_sched: sequencer for one accelerator job.
//   A job runs IDLE -> MATW (item-memory write) -> GAP -> RUN -> LAST -> DONE.
//   Protocol errors and watchdog expiry send it to ERR. abort returns it to IDLE.
// Ports:
//   AXIS_ACLK, AXIS_ARESETN      clock and async active-low reset
//   start, abort                 job control (start is a pulse, abort is a level)
//   cfg_item_num/chunk_num/timeout  job configuration, latched when start is accepted
//   src_fin, s_fin, dst_last_hs  progress events from the datapath
//   matw, run, last, busy, done, err  registered status outputs
//   chunk_cnt                    chunks received in the current job
module job_sched #(
  parameter int unsigned CW = 16
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_item_num,
  input  logic [CW-1:0] cfg_chunk_num,
  input  logic [CW-1:0] cfg_timeout,
  input  logic          src_fin,
  input  logic          s_fin,
  input  logic          dst_last_hs,
  output logic          matw,
  output logic          run,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW:0]   chunk_cnt
);

  typedef enum logic [2:0] {
    StIdle, StMatw, StGap, StRun, StLast, StDone, StErr
  } state_e;

  localparam logic [CW-1:0] OneCw  = CW'(1);
  localparam logic [CW:0]   OneCw1 = (CW+1)'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] item_num_q, chunk_num_q, timeout_q;
  logic [CW-1:0] item_cnt_q, item_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW:0]   chunk_cnt_q, chunk_cnt_d;
  logic          matw_d, run_d, last_d, busy_d, done_d, err_d;
  logic          start_acc;
  logic [CW:0]   chunk_inc, chunk_tgt, chunk_max;

  // start is accepted only when not busy; abort in the same cycle wins.
  assign start_acc = start && !abort && (state_q == StIdle || state_q == StErr);

  assign chunk_inc = chunk_cnt_q + OneCw1;
  assign chunk_tgt = {1'b0, chunk_num_q};
  // One chunk beyond the configured count is still legal to hold without wrapping.
  assign chunk_max = chunk_tgt + OneCw1;

  // State and counter registers.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q     <= StIdle;
      item_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      item_num_q  <= '0;
      chunk_num_q <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      item_cnt_q  <= item_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      if (start_acc) begin
        item_num_q  <= cfg_item_num;
        chunk_num_q <= cfg_chunk_num;
        timeout_q   <= cfg_timeout;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    item_cnt_d  = item_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    if (abort && state_q != StIdle) begin
      state_d     = StIdle;
      item_cnt_d  = '0;
      idle_cnt_d  = '0;
      chunk_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StErr: begin
          if (start_acc) begin
            state_d     = StMatw;
            item_cnt_d  = '0;
            idle_cnt_d  = '0;
            chunk_cnt_d = '0;
          end
        end
        StMatw: begin
          if (item_cnt_q == item_num_q) state_d = StGap;
          else                          item_cnt_d = item_cnt_q + OneCw;
        end
        StGap: begin
          idle_cnt_d = '0;
          state_d    = (chunk_num_q == '0) ? StLast : StRun;
        end
        StRun: begin
          if (dst_last_hs) begin
            state_d = StErr;
          end else if (src_fin) begin
            chunk_cnt_d = chunk_inc;
            idle_cnt_d  = '0;
            if (chunk_inc == chunk_tgt) state_d = StLast;
          end else if (s_fin) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == timeout_q) begin
            state_d = StErr;
          end else begin
            idle_cnt_d = idle_cnt_q + OneCw;
          end
        end
        StLast: begin
          if (dst_last_hs) begin
            // Completion wins over a simultaneous extra chunk; count saturates.
            state_d = StDone;
            if (src_fin && chunk_cnt_q != chunk_max) chunk_cnt_d = chunk_inc;
          end else if (src_fin) begin
            if (chunk_cnt_q == chunk_max) begin
              state_d = StErr;
            end else begin
              chunk_cnt_d = chunk_inc;
              idle_cnt_d  = '0;
            end
          end else if (s_fin) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == timeout_q) begin
            state_d = StErr;
          end else begin
            idle_cnt_d = idle_cnt_q + OneCw;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    matw_d = (state_d == StMatw);
    run_d  = (state_d == StRun) || (state_d == StLast);
    last_d = (state_d == StLast);
    busy_d = (state_d != StIdle) && (state_d != StErr);
    done_d = (state_d == StDone);
    err_d  = err;
    if (start_acc)              err_d = 1'b0;
    else if (state_d == StErr)  err_d = 1'b1;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      matw <= 1'b0;
      run  <= 1'b0;
      last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      matw <= matw_d;
      run  <= run_d;
      last <= last_d;
      busy <= busy_d;
      done <= done_d;
      err  <= err_d;
    end
  end

  assign chunk_cnt = chunk_cnt_q;

endmodule

// File: tb/tb_job_sched.sv
module tb_job_sched;
  localparam int unsigned CW = 16;

  logic          AXIS_ACLK = 1'b0;
  logic          AXIS_ARESETN;
  logic          start, abort, src_fin, s_fin, dst_last_hs;
  logic [CW-1:0] cfg_item_num, cfg_chunk_num, cfg_timeout;
  logic          matw, run, last, busy, done, err;
  logic [CW:0]   chunk_cnt;

  int errors = 0;
  int checks = 0;

  job_sched #(.CW(CW)) dut (
    .AXIS_ACLK    (AXIS_ACLK),
    .AXIS_ARESETN (AXIS_ARESETN),
    .start        (start),
    .abort        (abort),
    .cfg_item_num (cfg_item_num),
    .cfg_chunk_num(cfg_chunk_num),
    .cfg_timeout  (cfg_timeout),
    .src_fin      (src_fin),
    .s_fin        (s_fin),
    .dst_last_hs  (dst_last_hs),
    .matw         (matw),
    .run          (run),
    .last         (last),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .chunk_cnt    (chunk_cnt)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after a falling edge; outputs are read at falling edges.
  task automatic step();
    @(negedge AXIS_ACLK);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ev(input logic sf, input logic sc, input logic dl);
    src_fin = sf; s_fin = sc; dst_last_hs = dl;
    step();
    src_fin = 1'b0; s_fin = 1'b0; dst_last_hs = 1'b0;
  endtask

  initial begin
    int cnt;
    AXIS_ARESETN = 1'b0;
    start = 0; abort = 0; src_fin = 0; s_fin = 0; dst_last_hs = 0;
    cfg_item_num = '0; cfg_chunk_num = '0; cfg_timeout = '0;
    steps(2);
    chk("rst_matw", matw, 0);
    chk("rst_run", run, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", chunk_cnt, 0);
    AXIS_ARESETN = 1'b1;
    step();

    // Normal job: 100 item writes, 3 chunks; cfg is changed after start.
    cfg_item_num = 16'd99; cfg_chunk_num = 16'd2; cfg_timeout = 16'd1000;
    pulse_start();
    cfg_item_num = 16'd5; cfg_chunk_num = 16'd0;
    cnt = 0;
    while (matw && cnt < 300) begin
      cnt++;
      step();
    end
    chk("matw_cycles", cnt, 100);
    chk("gap_run", run, 0);
    chk("gap_busy", busy, 1);
    step();
    chk("run_entry", run, 1);
    chk("run_entry_last", last, 0);
    ev(1, 0, 0);
    chk("chunk1_cnt", chunk_cnt, 1);
    chk("chunk1_last", last, 0);
    ev(1, 0, 0);
    chk("chunk2_cnt", chunk_cnt, 2);
    chk("chunk2_last", last, 1);
    ev(1, 0, 0);
    chk("chunk3_cnt", chunk_cnt, 3);
    chk("chunk3_run", run, 1);
    ev(0, 0, 1);
    chk("done_pulse", done, 1);
    chk("done_run", run, 0);
    chk("done_busy", busy, 1);
    step();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("final_cnt", chunk_cnt, 3);

    // Single chunk: LAST on first streaming cycle; src_fin with dst_last_hs.
    cfg_item_num = 16'd3; cfg_chunk_num = 16'd0;
    pulse_start();
    steps(3);
    chk("matw_c4", matw, 1);
    step();
    chk("gap2_matw", matw, 0);
    step();
    chk("c0_last", last, 1);
    chk("c0_run", run, 1);
    ev(1, 0, 1);
    chk("c0_done", done, 1);
    chk("c0_cnt", chunk_cnt, 1);
    chk("c0_err", err, 0);
    step();

    // Early final handshake while still in RUN.
    cfg_item_num = 16'd0; cfg_chunk_num = 16'd3;
    pulse_start();
    steps(2);
    chk("early_run", run, 1);
    ev(0, 0, 1);
    chk("early_err", err, 1);
    chk("early_run_off", run, 0);
    chk("early_busy", busy, 0);

    // Restart from ERR, then watchdog with an s_fin refresh partway.
    cfg_timeout = 16'd15;
    pulse_start();
    chk("restart_err", err, 0);
    chk("restart_matw", matw, 1);
    steps(2);
    steps(10);
    ev(0, 1, 0);
    steps(15);
    chk("wd_still_run", run, 1);
    chk("wd_no_err", err, 0);
    step();
    chk("wd_err", err, 1);
    chk("wd_run_off", run, 0);

    // Abort on MATW cycle 10 together with start.
    cfg_item_num = 16'd20;
    pulse_start();
    chk("ab_err_clear", err, 0);
    steps(9);
    chk("ab_matw_c10", matw, 1);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("ab_matw", matw, 0);
    chk("ab_done", done, 0);
    chk("ab_busy", busy, 0);
    step();
    chk("ab_stay_idle", matw, 0);

    // start in RUN ignored; then an extra chunk in LAST.
    cfg_item_num = 16'd0; cfg_chunk_num = 16'd1; cfg_timeout = 16'd100;
    pulse_start();
    steps(2);
    pulse_start();
    chk("ign_matw", matw, 0);
    chk("ign_run", run, 1);
    ev(1, 0, 0);
    chk("x_last", last, 1);
    ev(1, 0, 0);
    chk("x_cnt", chunk_cnt, 2);
    chk("x_no_err", err, 0);
    ev(1, 0, 0);
    chk("x_err", err, 1);
    chk("x_cnt_hold", chunk_cnt, 2);

    // Reset pulse mid-RUN.
    pulse_start();
    steps(2);
    chk("pre_rst_run", run, 1);
    AXIS_ARESETN = 1'b0;
    #1;
    chk("async_run", run, 0);
    chk("async_busy", busy, 0);
    chk("async_cnt", chunk_cnt, 0);
    step();
    AXIS_ARESETN = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    ev(1, 0, 0);
    chk("idle_ignore_src", chunk_cnt, 0);
    chk("idle_stays", run, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
